dp_scb: RTL and testbench

Parametrised dispatch scoreboard for the vector unit, sitting between decode and the per-FU issue queues. It buffers up to `SN` decoded instructions and tracks RAW/WAW/WAR hazards on vector-register masks, clearing them from per-FU completion feedback. Each cycle it dispatches at most one hazard-free instruction to its functional unit: the oldest one in out-of-order mode, or only the oldest undispatched one in in-order mode. Entries retire once dispatched, sources read and destination written back.

---
 rtl/dp_pkg.sv | 37 +++
 rtl/dp_age_sel.sv | 31 +++
 rtl/dp_scb.sv | 204 ++++++++++++++++++++
 tb/tb_dp_scb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared types for the vector dispatch scoreboard: payload, FU index and
// the per-entry record held in each scoreboard slot.
package dp_pkg;

    // Widest register mask and FU index any scoreboard instance stores.
    localparam int DP_NREG = 32;
    localparam int DP_FU_W = 3;

    typedef enum logic [DP_FU_W-1:0] {
        FU_ALU = 3'd0,
        FU_MAC = 3'd1,
        FU_LD  = 3'd2,
        FU_ST  = 3'd3,
        FU_MSK = 3'd4,
        FU_SLD = 3'd5
    } fu_e;

    // Opaque decoded instruction, carried through unchanged.
    typedef struct packed {
        logic [7:0]  op;
        logic [23:0] imm;
    } dec_req_t;

    // One scoreboard slot. Age and dependency vectors live beside it
    // because their width follows the entry count.
    typedef struct packed {
        logic               valid;
        logic               dp;
        logic               vs_pend;
        logic               vd_pend;
        fu_e                fu;
        logic [DP_NREG-1:0] vs_mask;
        logic [DP_NREG-1:0] vd_mask;
        dec_req_t           req;
    } scb_entry_t;

endpackage

// File: rtl/dp_age_sel.sv
// Oldest-first picker: among the eligible entries, returns the one that has
// no eligible older entry, as a one-hot vector and as an index.
module dp_age_sel #(
    parameter int SN   = 8,
    parameter int ID_W = $clog2(SN)
) (
    input  logic [SN-1:0]         elig,
    input  logic [SN-1:0][SN-1:0] age,
    output logic [SN-1:0]         pick,
    output logic [ID_W-1:0]       id,
    output logic                  valid
);

    // Age rows are a strict order over live entries, so at most one bit of pick is set.
    always_comb begin
        pick = '0;
        id   = '0;
        for (int i = 0; i < SN; i++) begin
            if (elig[i] && !(|(age[i] & elig))) begin
                pick[i] = 1'b1;
            end
        end
        for (int i = 0; i < SN; i++) begin
            if (pick[i]) begin
                id = id | ID_W'(i);
            end
        end
        valid = |pick;
    end

endmodule

// File: rtl/dp_scb.sv
// Vector dispatch scoreboard. Buffers decoded instructions, tracks
// RAW/WAW/WAR hazards on register masks and dispatches one hazard-free
// entry per cycle to its functional unit, oldest first.
//
// Handshakes: a decode transfer happens in a cycle where dec_req_valid and
// dec_req_ready are both high; dec_req_ready depends only on registered
// state. A dispatch transfer happens in every cycle fu_req_valid[f] is high;
// it is only raised when fu_req_ready[f] is already high, so fu_req_ready
// must never depend on fu_req_valid.
module dp_scb
    import dp_pkg::*;
#(
    parameter int SN       = 8,
    parameter int NFU      = 6,
    parameter int NREG     = 32,
    parameter int IN_ORDER = 0,
    parameter int ID_W     = $clog2(SN),
    parameter int FU_W     = $clog2(NFU)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dec_req_valid,
    output logic                      dec_req_ready,
    input  dec_req_t                  dec_req,
    input  logic [FU_W-1:0]           dec_fu,
    input  logic [NREG-1:0]           dec_vs_mask,
    input  logic [NREG-1:0]           dec_vd_mask,
    input  logic [NFU-1:0]            fu_req_ready,
    output logic [NFU-1:0]            fu_req_valid,
    output dec_req_t                  dp_req,
    output logic [ID_W-1:0]           dp_id,
    input  logic [NFU-1:0]            fu_vs_done_valid,
    input  logic [NFU-1:0][ID_W-1:0]  fu_vs_done_id,
    input  logic [NFU-1:0]            fu_vd_done_valid,
    input  logic [NFU-1:0][ID_W-1:0]  fu_vd_done_id,
    output logic [ID_W:0]             scb_cnt,
    output logic                      scb_empty
);

    scb_entry_t            ent_q [SN];
    logic [SN-1:0][SN-1:0] age_q;
    logic [SN-1:0][SN-1:0] dep_wr_q;
    logic [SN-1:0][SN-1:0] dep_rd_q;

    logic [SN-1:0]      valid_v, dp_v, ret, fu_rdy, elig, pick;
    logic [SN-1:0]      vs_clr, vd_clr, vs_pend_n, vd_pend_n;
    logic [SN-1:0]      alloc_dep_wr, alloc_dep_rd;
    logic [NFU-1:0]     vs_bad, vd_bad;
    logic [ID_W-1:0]    alloc_id, sel_id;
    logic               alloc_en, alloc_found, sel_valid;
    logic [DP_NREG-1:0] vs_w, vd_w;

    assign vs_w = DP_NREG'(dec_vs_mask);
    assign vd_w = DP_NREG'(dec_vd_mask);

    // Flatten per-entry status and find entries whose work is finished.
    always_comb begin
        valid_v = '0;
        dp_v    = '0;
        ret     = '0;
        fu_rdy  = '0;
        for (int i = 0; i < SN; i++) begin
            valid_v[i] = ent_q[i].valid;
            dp_v[i]    = ent_q[i].dp;
            ret[i]     = ent_q[i].valid & ent_q[i].dp & ~ent_q[i].vs_pend & ~ent_q[i].vd_pend;
            for (int f = 0; f < NFU; f++) begin
                if (DP_FU_W'(ent_q[i].fu) == DP_FU_W'(f)) begin
                    fu_rdy[i] = fu_req_ready[f];
                end
            end
        end
    end

    // Decode per-FU done events into per-entry clears; anything not aimed at a
    // dispatched entry still waiting for that event is dropped and flagged.
    always_comb begin
        vs_clr = '0;
        vd_clr = '0;
        vs_bad = '0;
        vd_bad = '0;
        for (int f = 0; f < NFU; f++) begin
            for (int i = 0; i < SN; i++) begin
                if (fu_vs_done_valid[f] && fu_vs_done_id[f] == ID_W'(i)) begin
                    if (ent_q[i].valid && ent_q[i].dp && ent_q[i].vs_pend) vs_clr[i] = 1'b1;
                    else                                                   vs_bad[f] = 1'b1;
                end
                if (fu_vd_done_valid[f] && fu_vd_done_id[f] == ID_W'(i)) begin
                    if (ent_q[i].valid && ent_q[i].dp && ent_q[i].vd_pend) vd_clr[i] = 1'b1;
                    else                                                   vd_bad[f] = 1'b1;
                end
            end
        end
        for (int i = 0; i < SN; i++) begin
            vs_pend_n[i] = ent_q[i].vs_pend & ~vs_clr[i];
            vd_pend_n[i] = ent_q[i].vd_pend & ~vd_clr[i];
        end
    end

    // Allocation: lowest free slot; slots retiring this cycle are not yet free.
    always_comb begin
        alloc_id    = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < SN; i++) begin
            if (!alloc_found && !valid_v[i]) begin
                alloc_id    = ID_W'(i);
                alloc_found = 1'b1;
            end
        end
        dec_req_ready = ~&valid_v;
        alloc_en      = dec_req_valid & dec_req_ready;
    end

    // Hazards of the incoming instruction against live producers/readers,
    // using pending bits that already include this cycle's done events.
    always_comb begin
        alloc_dep_wr = '0;
        alloc_dep_rd = '0;
        for (int j = 0; j < SN; j++) begin
            alloc_dep_wr[j] = valid_v[j] & vd_pend_n[j] & (|((vs_w | vd_w) & ent_q[j].vd_mask));
            alloc_dep_rd[j] = valid_v[j] & vs_pend_n[j] & (|(vd_w & ent_q[j].vs_mask));
        end
    end

    // Eligibility from registered state and the target FU's ready.
    always_comb begin
        elig = '0;
        for (int i = 0; i < SN; i++) begin
            elig[i] = valid_v[i] & ~dp_v[i] & ~(|dep_wr_q[i]) & ~(|dep_rd_q[i]) & fu_rdy[i]
                    & ((IN_ORDER == 0) | ~(|(age_q[i] & valid_v & ~dp_v)));
        end
    end

    dp_age_sel #(.SN(SN), .ID_W(ID_W)) u_sel (
        .elig  (elig),
        .age   (age_q),
        .pick  (pick),
        .id    (sel_id),
        .valid (sel_valid)
    );

    // Dispatch outputs and occupancy.
    always_comb begin
        fu_req_valid = '0;
        dp_req       = '0;
        dp_id        = '0;
        scb_cnt      = '0;
        if (sel_valid) begin
            dp_id  = sel_id;
            dp_req = ent_q[sel_id].req;
            for (int f = 0; f < NFU; f++) begin
                if (DP_FU_W'(ent_q[sel_id].fu) == DP_FU_W'(f)) fu_req_valid[f] = 1'b1;
            end
        end
        for (int i = 0; i < SN; i++) begin
            scb_cnt = scb_cnt + (ID_W+1)'(valid_v[i]);
        end
        scb_empty = ~(|valid_v);
    end

    // Entry registers: allocate, mark dispatch, apply dones, retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SN; i++) begin
                ent_q[i] <= '0;
            end
            age_q    <= '0;
            dep_wr_q <= '0;
            dep_rd_q <= '0;
        end else begin
            for (int i = 0; i < SN; i++) begin
                if (alloc_en && alloc_id == ID_W'(i)) begin
                    ent_q[i].valid   <= 1'b1;
                    ent_q[i].dp      <= 1'b0;
                    ent_q[i].vs_pend <= |vs_w;
                    ent_q[i].vd_pend <= |vd_w;
                    ent_q[i].fu      <= fu_e'(DP_FU_W'(dec_fu));
                    ent_q[i].vs_mask <= vs_w;
                    ent_q[i].vd_mask <= vd_w;
                    ent_q[i].req     <= dec_req;
                    age_q[i]         <= valid_v & ~ret;
                    dep_wr_q[i]      <= alloc_dep_wr;
                    dep_rd_q[i]      <= alloc_dep_rd;
                end else begin
                    if (ret[i]) begin
                        ent_q[i].valid <= 1'b0;
                        ent_q[i].dp    <= 1'b0;
                    end else if (pick[i]) begin
                        ent_q[i].dp <= 1'b1;
                    end
                    ent_q[i].vs_pend <= vs_pend_n[i];
                    ent_q[i].vd_pend <= vd_pend_n[i];
                    age_q[i]         <= age_q[i] & ~ret;
                    dep_wr_q[i]      <= dep_wr_q[i] & ~vd_clr;
                    dep_rd_q[i]      <= dep_rd_q[i] & ~vs_clr;
                end
            end
        end
    end

    a_vs_done_legal: assert property (@(posedge clk) disable iff (!rst_n) vs_bad == '0);
    a_vd_done_legal: assert property (@(posedge clk) disable iff (!rst_n) vd_bad == '0);
    a_one_dispatch:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(fu_req_valid));

endmodule

// File: tb/tb_dp_scb.sv
// Randomized bench for dp_scb: an out-of-order and an in-order instance run
// side by side, each against a reference model that reasons over instructions
// in program order rather than over slots' dependency bits.
module tb_dp_scb;
    import dp_pkg::*;

    localparam int SN      = 8;
    localparam int NFU     = 6;
    localparam int NCYC    = 700;
    localparam int RST_CYC = 450;

    logic clk, rst_n;
    logic                 dec_req_valid [2];
    logic                 dec_req_ready [2];
    dec_req_t             dec_req [2];
    logic [2:0]           dec_fu [2];
    logic [31:0]          dec_vs_mask [2];
    logic [31:0]          dec_vd_mask [2];
    logic [NFU-1:0]       fu_req_ready [2];
    logic [NFU-1:0]       fu_req_valid [2];
    dec_req_t             dp_req [2];
    logic [2:0]           dp_id [2];
    logic [NFU-1:0]       fu_vs_done_valid [2];
    logic [NFU-1:0][2:0]  fu_vs_done_id [2];
    logic [NFU-1:0]       fu_vd_done_valid [2];
    logic [NFU-1:0][2:0]  fu_vd_done_id [2];
    logic [3:0]           scb_cnt [2];
    logic                 scb_empty [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dp_scb #(.SN(SN), .NFU(NFU), .NREG(32), .IN_ORDER(g)) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .dec_req_valid    (dec_req_valid[g]),
            .dec_req_ready    (dec_req_ready[g]),
            .dec_req          (dec_req[g]),
            .dec_fu           (dec_fu[g]),
            .dec_vs_mask      (dec_vs_mask[g]),
            .dec_vd_mask      (dec_vd_mask[g]),
            .fu_req_ready     (fu_req_ready[g]),
            .fu_req_valid     (fu_req_valid[g]),
            .dp_req           (dp_req[g]),
            .dp_id            (dp_id[g]),
            .fu_vs_done_valid (fu_vs_done_valid[g]),
            .fu_vs_done_id    (fu_vs_done_id[g]),
            .fu_vd_done_valid (fu_vd_done_valid[g]),
            .fu_vd_done_id    (fu_vd_done_id[g]),
            .scb_cnt          (scb_cnt[g]),
            .scb_empty        (scb_empty[g])
        );
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit          alive;
        bit          dp;
        bit          vsp;
        bit          vdp;
        logic [31:0] vs;
        logic [31:0] vd;
        int          fu;
        int          seq;
        logic [31:0] req;
    } ment_t;

    ment_t mdl [2][SN];
    int    seq_ctr [2];

    logic [34:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          saw_full = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            seq_ctr[k] = 0;
            for (int i = 0; i < SN; i++) begin
                mdl[k][i].alive = 0; mdl[k][i].dp  = 0;
                mdl[k][i].vsp   = 0; mdl[k][i].vdp = 0;
                mdl[k][i].vs    = '0; mdl[k][i].vd = '0;
                mdl[k][i].fu    = 0; mdl[k][i].seq = 0;
                mdl[k][i].req   = '0;
            end
        end
    endfunction

    // An instruction waits on any earlier live instruction whose pending write
    // touches what it reads or writes, or whose pending read touches what it writes.
    function automatic bit blocked(int k, int i);
        for (int j = 0; j < SN; j++) begin
            if (j != i && mdl[k][j].alive && mdl[k][j].seq < mdl[k][i].seq) begin
                if (mdl[k][j].vdp && (((mdl[k][i].vs | mdl[k][i].vd) & mdl[k][j].vd) != 0)) return 1;
                if (mdl[k][j].vsp && ((mdl[k][i].vd & mdl[k][j].vs) != 0)) return 1;
            end
        end
        return 0;
    endfunction

    function automatic bit older_undispatched(int k, int i);
        for (int j = 0; j < SN; j++) begin
            if (mdl[k][j].alive && !mdl[k][j].dp && mdl[k][j].seq < mdl[k][i].seq) return 1;
        end
        return 0;
    endfunction

    function automatic int pick_idx(int k);
        int best = -1;
        for (int i = 0; i < SN; i++) begin
            if (mdl[k][i].alive && !mdl[k][i].dp && fu_req_ready[k][mdl[k][i].fu] && !blocked(k, i)
                && !(k == 1 && older_undispatched(k, i))) begin
                if (best < 0 || mdl[k][i].seq < mdl[k][best].seq) best = i;
            end
        end
        return best;
    endfunction

    function automatic int live_cnt(int k);
        int c = 0;
        for (int i = 0; i < SN; i++) if (mdl[k][i].alive) c++;
        return c;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input int k, input int cyc);
        int cand[$];
        int r;
        if (cyc >= 150 && cyc < 230)      fu_req_ready[k] = '0;
        else if (cyc >= 230 && cyc < 260) fu_req_ready[k] = 6'b000001;
        else                              fu_req_ready[k] = NFU'($urandom_range(0, 63));
        dec_req_valid[k] = ($urandom_range(0, 99) < 55);
        r = $urandom_range(0, 3);
        dec_vs_mask[k] = (r == 0) ? 32'h0 : ((32'h1 << $urandom_range(0, 7))
                         | ((r == 3) ? (32'h1 << $urandom_range(0, 31)) : 32'h0));
        dec_vd_mask[k] = ($urandom_range(0, 3) == 0) ? 32'h0 : (32'h1 << $urandom_range(0, 7));
        dec_fu[k]      = 3'($urandom_range(0, NFU - 1));
        dec_req[k]     = $urandom;
        fu_vs_done_valid[k] = '0;
        fu_vd_done_valid[k] = '0;
        fu_vs_done_id[k]    = '0;
        fu_vd_done_id[k]    = '0;
        for (int f = 0; f < NFU; f++) begin
            cand.delete();
            for (int i = 0; i < SN; i++)
                if (mdl[k][i].alive && mdl[k][i].dp && mdl[k][i].fu == f && mdl[k][i].vsp) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                fu_vs_done_valid[k][f] = 1'b1;
                fu_vs_done_id[k][f]    = 3'(cand[$urandom_range(0, cand.size() - 1)]);
            end
            cand.delete();
            for (int i = 0; i < SN; i++)
                if (mdl[k][i].alive && mdl[k][i].dp && mdl[k][i].fu == f && mdl[k][i].vdp) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                fu_vd_done_valid[k][f] = 1'b1;
                fu_vd_done_id[k][f]    = 3'(cand[$urandom_range(0, cand.size() - 1)]);
            end
        end
    endtask

    // ---------------- scoreboard: compare then advance the model ----------------
    task automatic check_step(input int k);
        int  p, cnt, slot;
        bit  ret [SN];
        logic [NFU-1:0] exp_fv;
        cnt = live_cnt(k);
        if (!dec_req_ready[k]) saw_full = 1;
        check($sformatf("ready%0d", k), 64'(dec_req_ready[k]), 64'(cnt < SN));
        check($sformatf("cnt%0d", k), 64'(scb_cnt[k]), 64'(cnt));
        check($sformatf("empty%0d", k), 64'(scb_empty[k]), 64'(cnt == 0));
        p = pick_idx(k);
        exp_fv = (p >= 0) ? NFU'(1 << mdl[k][p].fu) : '0;
        check($sformatf("fu_req_valid%0d", k), 64'(fu_req_valid[k]), 64'(exp_fv));
        if (p >= 0) exp_q.push_back({3'(p), mdl[k][p].req});
        if (fu_req_valid[k] != '0) begin
            check($sformatf("dp_expected%0d", k), 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) check($sformatf("dp_id_req%0d", k), 64'({dp_id[k], dp_req[k]}), 64'(exp_q.pop_front()));
        end else begin
            check($sformatf("dp_none_expected%0d", k), 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
        // advance to the state after the coming edge
        for (int i = 0; i < SN; i++)
            ret[i] = mdl[k][i].alive && mdl[k][i].dp && !mdl[k][i].vsp && !mdl[k][i].vdp;
        if (p >= 0) mdl[k][p].dp = 1;
        for (int f = 0; f < NFU; f++) begin
            if (fu_vs_done_valid[k][f]) mdl[k][fu_vs_done_id[k][f]].vsp = 0;
            if (fu_vd_done_valid[k][f]) mdl[k][fu_vd_done_id[k][f]].vdp = 0;
        end
        if (dec_req_valid[k] && cnt < SN) begin
            slot = -1;
            for (int i = 0; i < SN; i++) if (slot < 0 && !mdl[k][i].alive) slot = i;
            mdl[k][slot].alive = 1;
            mdl[k][slot].dp    = 0;
            mdl[k][slot].vs    = dec_vs_mask[k];
            mdl[k][slot].vd    = dec_vd_mask[k];
            mdl[k][slot].vsp   = (dec_vs_mask[k] != 0);
            mdl[k][slot].vdp   = (dec_vd_mask[k] != 0);
            mdl[k][slot].fu    = int'(dec_fu[k]);
            mdl[k][slot].req   = dec_req[k];
            mdl[k][slot].seq   = seq_ctr[k]++;
        end
        for (int i = 0; i < SN; i++) if (ret[i]) mdl[k][i].alive = 0;
    endtask

    task automatic check_reset();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_ready%0d", k), 64'(dec_req_ready[k]), 64'(1));
            check($sformatf("rst_cnt%0d", k), 64'(scb_cnt[k]), 64'(0));
            check($sformatf("rst_empty%0d", k), 64'(scb_empty[k]), 64'(1));
            check($sformatf("rst_fu_req_valid%0d", k), 64'(fu_req_valid[k]), 64'(0));
            check($sformatf("rst_dp_id%0d", k), 64'(dp_id[k]), 64'(0));
            check($sformatf("rst_dp_req%0d", k), 64'(dp_req[k]), 64'(0));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dec_req_valid[k] = 0; dec_req[k] = '0; dec_fu[k] = '0;
            dec_vs_mask[k] = '0; dec_vd_mask[k] = '0; fu_req_ready[k] = '0;
            fu_vs_done_valid[k] = '0; fu_vs_done_id[k] = '0;
            fu_vd_done_valid[k] = '0; fu_vd_done_id[k] = '0;
        end
        model_clear();
        repeat (2) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc == RST_CYC) begin
                rst_n = 1'b0;
                #1;
                check_reset();
                model_clear();
                exp_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int k = 0; k < 2; k++) drive(k, cyc);
            #1;
            for (int k = 0; k < 2; k++) check_step(k);
        end
        check("saw_full", 64'(saw_full), 64'(1));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
